// File: rtl/mem_load_store_unit.sv
// Data-memory load/store unit: alignment check, lane steering,
// single outstanding bus access with ack timeout.
module mem_load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [31:0] ALU_Result_MEM,
   input  logic [31:0] Write_Data_MEM,
   input  logic        MemRead_MEM,
   input  logic        MemWrite_MEM,
   input  logic [1:0]  Mem_Size_MEM,
   input  logic        Mem_Signed_MEM,
   output logic [31:0] Read_Data_MEM,
   output logic        Stall_MEM,
   output logic        Misaligned_MEM,
   output logic        Bus_Error,
   output logic        Mem_Req,
   output logic        Mem_We,
   output logic [31:0] Mem_Addr,
   output logic [31:0] Mem_Wdata,
   output logic [3:0]  Mem_Be,
   input  logic        Mem_Ack,
   input  logic [31:0] Mem_Rdata
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] count;
   logic          access;
   logic          is_write;
   logic          aligned;
   logic          start;
   logic          timeout;
   logic [3:0]    be;
   logic [31:0]   wdata;
   logic [1:0]    lo_q;
   logic [1:0]    size_q;
   logic          sgn_q;
   logic [31:0]   lane;
   logic [31:0]   load;

   assign access   = MemRead_MEM | MemWrite_MEM;
   assign is_write = MemWrite_MEM & ~MemRead_MEM;
   assign start    = (state == IDLE) & access & aligned;
   assign timeout  = (count == CW'(TIMEOUT_CYCLES - 1));

   // Reset gating keeps the combinational stall at 0 while held in reset.
   assign Stall_MEM = Reset_n & (start | (state == REQ));

   // Alignment check plus byte-enable and lane-replicated store data.
   always_comb begin
      aligned = 1'b0;
      be      = 4'b0000;
      wdata   = Write_Data_MEM;
      case (Mem_Size_MEM)
         2'b00: begin
            aligned = 1'b1;
            be      = 4'b0001 << ALU_Result_MEM[1:0];
            wdata   = {4{Write_Data_MEM[7:0]}};
         end
         2'b01: begin
            aligned = ~ALU_Result_MEM[0];
            be      = ALU_Result_MEM[1] ? 4'b1100 : 4'b0011;
            wdata   = {2{Write_Data_MEM[15:0]}};
         end
         2'b10: begin
            aligned = (ALU_Result_MEM[1:0] == 2'b00);
            be      = 4'b1111;
         end
         default: aligned = 1'b0;
      endcase
   end

   // Select the addressed lane of the read word and extend it.
   always_comb begin
      lane = Mem_Rdata >> {lo_q, 3'b000};
      case (size_q)
         2'b00:   load = {{24{sgn_q & lane[7]}}, lane[7:0]};
         2'b01:   load = {{16{sgn_q & lane[15]}}, lane[15:0]};
         default: load = lane;
      endcase
   end

   // Next-state logic; ack wins over a simultaneous timeout.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = REQ;
         REQ:     if (Mem_Ack || timeout) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Bus outputs, cycle counter, pulses and the load result register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         count          <= '0;
         Read_Data_MEM  <= '0;
         Misaligned_MEM <= 1'b0;
         Bus_Error      <= 1'b0;
         Mem_Req        <= 1'b0;
         Mem_We         <= 1'b0;
         Mem_Addr       <= '0;
         Mem_Wdata      <= '0;
         Mem_Be         <= '0;
         lo_q           <= '0;
         size_q         <= '0;
         sgn_q          <= 1'b0;
      end else begin
         Misaligned_MEM <= (state == IDLE) & access & ~aligned;
         Bus_Error      <= (state == REQ) & ~Mem_Ack & timeout;
         if (start) begin
            count     <= '0;
            Mem_Req   <= 1'b1;
            Mem_We    <= is_write;
            Mem_Addr  <= {ALU_Result_MEM[31:2], 2'b00};
            Mem_Wdata <= wdata;
            Mem_Be    <= be;
            lo_q      <= ALU_Result_MEM[1:0];
            size_q    <= Mem_Size_MEM;
            sgn_q     <= Mem_Signed_MEM;
         end else if (state == REQ) begin
            if (Mem_Ack) begin
               Mem_Req <= 1'b0;
               if (!Mem_We) Read_Data_MEM <= load;
            end else if (timeout) begin
               Mem_Req <= 1'b0;
               if (!Mem_We) Read_Data_MEM <= '0;
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_load_store_unit.sv
// Bench for mem_load_store_unit: directed cases then random
// accesses against an arithmetic reference model.
module tb_mem_load_store_unit;

   localparam int TO = 4;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic [31:0] ALU_Result_MEM = '0;
   logic [31:0] Write_Data_MEM = '0;
   logic        MemRead_MEM = 1'b0;
   logic        MemWrite_MEM = 1'b0;
   logic [1:0]  Mem_Size_MEM = '0;
   logic        Mem_Signed_MEM = 1'b0;
   logic [31:0] Read_Data_MEM;
   logic        Stall_MEM;
   logic        Misaligned_MEM;
   logic        Bus_Error;
   logic        Mem_Req;
   logic        Mem_We;
   logic [31:0] Mem_Addr;
   logic [31:0] Mem_Wdata;
   logic [3:0]  Mem_Be;
   logic        Mem_Ack = 1'b0;
   logic [31:0] Mem_Rdata = '0;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_rd = '0;

   mem_load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .ALU_Result_MEM(ALU_Result_MEM),
      .Write_Data_MEM(Write_Data_MEM),
      .MemRead_MEM(MemRead_MEM),
      .MemWrite_MEM(MemWrite_MEM),
      .Mem_Size_MEM(Mem_Size_MEM),
      .Mem_Signed_MEM(Mem_Signed_MEM),
      .Read_Data_MEM(Read_Data_MEM),
      .Stall_MEM(Stall_MEM),
      .Misaligned_MEM(Misaligned_MEM),
      .Bus_Error(Bus_Error),
      .Mem_Req(Mem_Req),
      .Mem_We(Mem_We),
      .Mem_Addr(Mem_Addr),
      .Mem_Wdata(Mem_Wdata),
      .Mem_Be(Mem_Be),
      .Mem_Ack(Mem_Ack),
      .Mem_Rdata(Mem_Rdata)
   );

   always #5 Clk = ~Clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] size);
      return 1 << size;
   endfunction

   function automatic bit legal(input logic [31:0] a, input logic [1:0] size);
      if (size == 2'b11) return 1'b0;
      return (a % nbytes(size)) == 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] size);
      int n;
      n = nbytes(size);
      return 4'(((1 << n) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] size);
      if (size == 2'b00) return {24'b0, wd[7:0]} * 32'h0101_0101;
      if (size == 2'b01) return {16'b0, wd[15:0]} * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] size,
                                          input logic sgn, input logic [31:0] rdata);
      logic [31:0] sh;
      logic [31:0] mask;
      int n;
      n = nbytes(size);
      sh = rdata >> (8 * (a % 4));
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      if (sgn && sh[8*n-1]) return sh | ~mask;
      return sh & mask;
   endfunction

   task automatic clear_inputs();
      MemRead_MEM = 1'b0;
      MemWrite_MEM = 1'b0;
      ALU_Result_MEM = '0;
      Write_Data_MEM = '0;
      Mem_Size_MEM = '0;
      Mem_Signed_MEM = 1'b0;
   endtask

   // Called at a negedge in IDLE; returns at a negedge in IDLE.
   // ack_at: REQ cycle (1..TO) that sees Mem_Ack, 0 = never.
   task automatic access(input logic [31:0] a, input logic [31:0] wd,
                         input logic rd, input logic wr,
                         input logic [1:0] size, input logic sgn,
                         input int ack_at, input logic [31:0] rdata,
                         output int stall_cnt);
      bit ok;
      bit fin;
      bit tmo;
      int k;
      ok = legal(a, size);
      ALU_Result_MEM = a;
      Write_Data_MEM = wd;
      MemRead_MEM = rd;
      MemWrite_MEM = wr;
      Mem_Size_MEM = size;
      Mem_Signed_MEM = sgn;
      #1;
      check("stall_idle", 32'(Stall_MEM), 32'(ok));
      stall_cnt = int'(Stall_MEM);
      if (!ok) begin
         @(negedge Clk);
         check("misaligned_pulse", 32'(Misaligned_MEM), 32'd1);
         check("misaligned_req", 32'(Mem_Req), 32'd0);
         check("misaligned_stall", 32'(Stall_MEM), 32'd0);
         clear_inputs();
         @(negedge Clk);
         check("misaligned_end", 32'(Misaligned_MEM), 32'd0);
         check("misaligned_req2", 32'(Mem_Req), 32'd0);
         check("misaligned_rd", Read_Data_MEM, exp_rd);
         return;
      end
      k = 0;
      fin = 1'b0;
      while (!fin) begin
         @(negedge Clk);
         k++;
         check("req", 32'(Mem_Req), 32'd1);
         check("we", 32'(Mem_We), 32'(wr & ~rd));
         check("addr", Mem_Addr, {a[31:2], 2'b00});
         check("wdata", Mem_Wdata, m_wdata(wd, size));
         check("be", 32'(Mem_Be), 32'(m_be(a, size)));
         check("stall_req", 32'(Stall_MEM), 32'd1);
         check("buserr_req", 32'(Bus_Error), 32'd0);
         stall_cnt += int'(Stall_MEM);
         if (k == ack_at) begin
            Mem_Ack = 1'b1;
            Mem_Rdata = rdata;
            fin = 1'b1;
         end else begin
            Mem_Ack = 1'b0;
            Mem_Rdata = $urandom;
            if (k >= TO) fin = 1'b1;
         end
      end
      @(negedge Clk);
      Mem_Ack = 1'b0;
      tmo = (ack_at == 0);
      if (rd) exp_rd = tmo ? 32'd0 : m_load(a, size, sgn, rdata);
      check("done_req", 32'(Mem_Req), 32'd0);
      check("done_stall", 32'(Stall_MEM), 32'd0);
      check("done_buserr", 32'(Bus_Error), 32'(tmo));
      check("done_rd", Read_Data_MEM, exp_rd);
      clear_inputs();
      @(negedge Clk);
      check("idle_buserr", 32'(Bus_Error), 32'd0);
      check("idle_req", 32'(Mem_Req), 32'd0);
      check("idle_rd", Read_Data_MEM, exp_rd);
   endtask

   initial begin
      int sc;
      logic [31:0] ra;
      logic [1:0]  rs;
      logic        rr;
      logic        rw;

      #2;
      check("rst_rd", Read_Data_MEM, 32'd0);
      check("rst_stall", 32'(Stall_MEM), 32'd0);
      check("rst_mis", 32'(Misaligned_MEM), 32'd0);
      check("rst_buserr", 32'(Bus_Error), 32'd0);
      check("rst_req", 32'(Mem_Req), 32'd0);
      check("rst_we", 32'(Mem_We), 32'd0);
      check("rst_addr", Mem_Addr, 32'd0);
      check("rst_wdata", Mem_Wdata, 32'd0);
      check("rst_be", 32'(Mem_Be), 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      access(32'h100, 32'h0, 1, 0, 2'b10, 0, 3, 32'hDEAD_BEEF, sc);
      check("word_ld_stall_cycles", 32'(sc), 32'd4);
      check("word_ld_data", Read_Data_MEM, 32'hDEAD_BEEF);

      access(32'h103, 32'h0, 1, 0, 2'b00, 1, 1, 32'h80FF_1234, sc);
      check("sbyte_ld", Read_Data_MEM, 32'hFFFF_FF80);
      access(32'h103, 32'h0, 1, 0, 2'b00, 0, 2, 32'h80FF_1234, sc);
      check("ubyte_ld", Read_Data_MEM, 32'h0000_0080);

      access(32'h102, 32'h0000_ABCD, 0, 1, 2'b01, 0, 2, 32'h0, sc);
      check("half_st_keeps_rd", Read_Data_MEM, 32'h0000_0080);

      access(32'h101, 32'h0, 1, 0, 2'b10, 0, 1, 32'h0, sc);
      access(32'h100, 32'h0, 1, 0, 2'b11, 0, 1, 32'h0, sc);

      access(32'h204, 32'h0, 1, 1, 2'b10, 0, 1, 32'h1357_9BDF, sc);
      check("rdwr_is_read", Read_Data_MEM, 32'h1357_9BDF);

      access(32'h300, 32'h0, 1, 0, 2'b10, 0, 0, 32'h0, sc);
      check("timeout_rd", Read_Data_MEM, 32'd0);
      check("timeout_stall_cycles", 32'(sc), 32'(TO + 1));

      access(32'h306, 32'h0, 1, 0, 2'b01, 1, 4, 32'h8001_7FFF, sc);
      check("half_ld_hi", Read_Data_MEM, 32'hFFFF_8001);

      Mem_Ack = 1'b1;
      Mem_Rdata = 32'h5555_AAAA;
      @(negedge Clk);
      Mem_Ack = 1'b0;
      check("idle_ack_ignored", Read_Data_MEM, 32'hFFFF_8001);
      check("idle_ack_req", 32'(Mem_Req), 32'd0);

      ALU_Result_MEM = 32'h400;
      MemRead_MEM = 1'b1;
      Mem_Size_MEM = 2'b10;
      @(negedge Clk);
      check("mid_req_active", 32'(Mem_Req), 32'd1);
      @(negedge Clk);
      Reset_n = 1'b0;
      #1;
      exp_rd = 32'd0;
      check("arst_req", 32'(Mem_Req), 32'd0);
      check("arst_stall", 32'(Stall_MEM), 32'd0);
      check("arst_be", 32'(Mem_Be), 32'd0);
      check("arst_rd", Read_Data_MEM, 32'd0);
      clear_inputs();
      @(negedge Clk);
      Reset_n = 1'b1;
      Mem_Ack = 1'b1;
      Mem_Rdata = 32'h1234_5678;
      @(negedge Clk);
      Mem_Ack = 1'b0;
      check("late_ack_rd", Read_Data_MEM, 32'd0);
      check("late_ack_req", 32'(Mem_Req), 32'd0);
      check("late_ack_stall", 32'(Stall_MEM), 32'd0);

      for (int i = 0; i < 60; i++) begin
         ra = $urandom;
         rs = 2'($urandom_range(0, 3));
         if (($urandom & 1) == 0) ra[1:0] = 2'b00;
         rr = 1'($urandom);
         rw = 1'($urandom);
         if (!rr && !rw) rr = 1'b1;
         access(ra, $urandom, rr, rw, rs, 1'($urandom),
                $urandom_range(0, TO), $urandom, sc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
